// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, forwarding and result-select encodings for the pipeline control
package cpu_pkg;
  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} mem_state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] RS_LOAD = 2'b01;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: decode-comparator and execute-operand forwarding selects
module forward_unit
  import cpu_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);
  logic m_ok, w_ok;
  always_comb begin
    m_ok = RegWriteM && RdM != 5'd0;
    w_ok = RegWriteW && RdW != 5'd0;
    ForwardAD = m_ok && RdM == Rs1D;
    ForwardBD = m_ok && RdM == Rs2D;
    ForwardAE = (m_ok && RdM == Rs1E) ? FWD_M : (w_ok && RdW == Rs1E) ? FWD_W : FWD_RF;
    ForwardBE = (m_ok && RdM == Rs2E) ? FWD_M : (w_ok && RdW == Rs2E) ? FWD_W : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with data-memory wait FSM and stall counter
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       ResultSrcM,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT - 1);
  mem_state_e state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic fad, fbd;
  logic [1:0] fae, fbe;
  logic pending, in_wait, timeout, memstall, lwstall, brstall, dstall;
  forward_unit u_fwd (
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAD(fad), .ForwardBD(fbd), .ForwardAE(fae), .ForwardBE(fbe)
  );
  always_comb begin
    pending = MemReqM && !MemAckM;
    in_wait = state_q == MWAIT;
    timeout = in_wait && pending && wcnt_q == WMAX;
    memstall = pending && !timeout;
    lwstall = ResultSrcE == RS_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    brstall = BranchD && ((RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D)) ||
              (ResultSrcM == RS_LOAD && RdM != 5'd0 && (RdM == Rs1D || RdM == Rs2D)));
    dstall = !memstall && (lwstall || brstall);
    StallF = !rst && (memstall || dstall);
    StallD = StallF;
    StallE = !rst && memstall;
    StallM = StallE;
    FlushD = rst || (!memstall && !dstall && (PCSrcD || JumpD));
    FlushE = rst || dstall;
    FlushW = rst || memstall;
    ForwardAD = !rst && fad;
    ForwardBD = !rst && fbd;
    ForwardAE = rst ? FWD_RF : fae;
    ForwardBE = rst ? FWD_RF : fbe;
    MemErr = !rst && timeout;
    state_d = in_wait ? ((!MemReqM || MemAckM || timeout) ? RUN : MWAIT) : (pending ? MWAIT : RUN);
    wcnt_d = (in_wait && state_d == MWAIT) ? ((wcnt_q == WMAX) ? wcnt_q : wcnt_q + 1'b1) : '0;
    stall_cnt_d = (StallF && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  assign StallCnt = stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
